// File: rtl/merge_n.sv
// ---------------------------------------------------------------------------
// merge_n
//
// Parametrised N-way merge for the synchronous NoC datapath. Words from
// NUM_IN input channels are funnelled into a single output channel through
// a small FIFO. Every word carries the index of the input it came from.
//
// Two operating modes, fixed at elaboration time by MODE:
//   MODE = 0 (CONTROLLED) : a select token on the control channel names the
//                           input that delivers the next word.
//   MODE = 1 (ARBITRATED) : a round-robin arbiter picks among the valid
//                           inputs; the control channel is ignored.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    per-input valid
//   in_ready    per-input ready
//   in_data     flattened input words, input i at [i*WIDTH +: WIDTH]
//   ctrl_valid  select token valid (CONTROLLED only)
//   ctrl_ready  select token accepted (always 0 when ARBITRATED)
//   ctrl_sel    requested input index
//   out_valid   FIFO not empty
//   out_ready   consumer accepts the head word
//   out_data    head word (0 while the FIFO is empty)
//   out_src     source index of the head word (0 while the FIFO is empty)
//   sel_err     one-cycle pulse after an out-of-range select was accepted
// ---------------------------------------------------------------------------
module merge_n #(
    parameter int NUM_IN = 3,
    parameter int WIDTH  = 11,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int DEPTH  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    ctrl_valid,
    output logic                    ctrl_ready,
    input  logic [SEL_W-1:0]        ctrl_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW1   = SEL_W + 1;

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_IN - 1);
    localparam logic [SW1-1:0]   NUM_IN_C  = SW1'(NUM_IN);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_DATA
    } state_t;

    // Control FSM state
    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic             run_q;
    logic             sel_err_q;

    // Round-robin pointer
    logic [SEL_W-1:0] rr_ptr;

    // Output FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_data [SLOTS];
    logic [SEL_W-1:0] mem_src  [SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Datapath glue
    logic             push_ok;
    logic             push;
    logic             pop;
    logic             ctrl_hs;
    logic             sel_oor;
    logic [SEL_W-1:0] winner;
    logic             winner_found;
    logic [SW1-1:0]   scan_sum;
    logic [SEL_W-1:0] push_src;
    logic [WIDTH-1:0] push_data;

    // The FIFO accepts a new word only while it has a free slot. A pop in the
    // same cycle does not free a slot early, so a full FIFO never passes a
    // word straight through.
    assign push_ok   = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // The head word is masked while empty so the output bus reads zero after
    // reset instead of whatever the uninitialised storage holds.
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_src  = out_valid ? mem_src[rd_ptr]  : '0;

    // The control channel is only live in CONTROLLED mode, and only once the
    // block has seen its first clock edge out of reset. run_q keeps every
    // ready low while reset is held, whatever the inputs are doing.
    assign ctrl_ready = (MODE == 0) ? (run_q && (state == IDLE)) : 1'b0;
    assign ctrl_hs    = ctrl_valid && ctrl_ready;
    assign sel_oor    = ({1'b0, ctrl_sel} >= NUM_IN_C);
    assign sel_err    = sel_err_q;

    // Round-robin search: scan ptr, ptr+1, ... modulo NUM_IN and keep the
    // first valid input. The loop runs from the farthest candidate back to
    // the pointer so that the nearest valid input is the last one written,
    // which avoids needing an early exit.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        scan_sum     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + SW1'(k);
            if (scan_sum >= NUM_IN_C) begin
                scan_sum = scan_sum - NUM_IN_C;
            end
            if (in_valid[scan_sum[SEL_W-1:0]]) begin
                winner       = scan_sum[SEL_W-1:0];
                winner_found = 1'b1;
            end
        end
    end

    // Ready generation. In CONTROLLED mode only the latched input may be
    // offered a slot, so unselected producers are never consumed. In
    // ARBITRATED mode the grant is one-hot on the round-robin winner.
    // Either way nothing is offered while the FIFO is full.
    always_comb begin
        in_ready = '0;
        if (run_q && push_ok) begin
            if (MODE == 0) begin
                if (state == WAIT_DATA) begin
                    in_ready[sel_q] = 1'b1;
                end
            end else if (winner_found) begin
                in_ready[winner] = 1'b1;
            end
        end
    end

    // Pick the word being written into the FIFO this cycle. At most one
    // in_ready bit is ever high, so a push always comes from push_src.
    assign push_src = (MODE == 0) ? sel_q : winner;
    assign push     = |(in_valid & in_ready);

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == push_src) begin
                push_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM. IDLE waits for a select token; WAIT_DATA waits for the
    // selected input to hand over one word. An out-of-range select is clamped
    // to the last input and flagged with a one-cycle sel_err pulse. In
    // ARBITRATED mode ctrl_ready is tied low, so the FSM simply parks in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            run_q     <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            sel_err_q <= ctrl_hs && sel_oor;
            case (state)
                IDLE: begin
                    if (ctrl_hs) begin
                        sel_q <= sel_oor ? LAST_SEL : ctrl_sel;
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (push) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Round-robin pointer: after every accepted word the input just served
    // drops to lowest priority. Idle cycles leave the pointer untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if ((MODE != 0) && push) begin
            rr_ptr <= (winner == LAST_SEL) ? '0 : winner + 1'b1;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap at DEPTH rather than at the
    // power-of-two storage size, so non-power-of-two depths work. A push and
    // pop in the same cycle leave the count where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. It needs no reset: the count and the output masking make
    // stale entries invisible, which is how a reset discards queued words.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_src[wr_ptr]  <= push_src;
        end
    end

endmodule

// File: tb/tb_merge_n.sv
// ---------------------------------------------------------------------------
// tb_merge_n
//
// Self-checking bench for merge_n. Two instances share clock and reset:
//   dut_c : CONTROLLED, NUM_IN=3, WIDTH=11, DEPTH=2
//   dut_a : ARBITRATED, NUM_IN=4, WIDTH=11, DEPTH=2
// The arbitrated instance is checked against a queue-based reference model
// holding the round-robin pointer and the expected FIFO contents.
// ---------------------------------------------------------------------------
module tb_merge_n;

    localparam int W = 11;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    // Controlled instance signals
    logic [2:0]     c_in_valid;
    logic [2:0]     c_in_ready;
    logic [3*W-1:0] c_in_data;
    logic           c_ctrl_valid;
    logic           c_ctrl_ready;
    logic [1:0]     c_ctrl_sel;
    logic           c_out_valid;
    logic           c_out_ready;
    logic [W-1:0]   c_out_data;
    logic [1:0]     c_out_src;
    logic           c_sel_err;

    // Arbitrated instance signals
    logic [3:0]     a_in_valid;
    logic [3:0]     a_in_ready;
    logic [4*W-1:0] a_in_data;
    logic           a_ctrl_valid;
    logic           a_ctrl_ready;
    logic [1:0]     a_ctrl_sel;
    logic           a_out_valid;
    logic           a_out_ready;
    logic [W-1:0]   a_out_data;
    logic [1:0]     a_out_src;
    logic           a_sel_err;

    // Reference model state for the arbitrated instance
    int             a_ptr;
    logic [12:0]    aq[$];
    logic [W-1:0]   a_prod [4];

    merge_n #(.NUM_IN(3), .WIDTH(W), .DEPTH(2), .MODE(0)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .ctrl_valid(c_ctrl_valid),
        .ctrl_ready(c_ctrl_ready),
        .ctrl_sel  (c_ctrl_sel),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .out_src   (c_out_src),
        .sel_err   (c_sel_err)
    );

    merge_n #(.NUM_IN(4), .WIDTH(W), .DEPTH(2), .MODE(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .ctrl_valid(a_ctrl_valid),
        .ctrl_ready(a_ctrl_ready),
        .ctrl_sel  (a_ctrl_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_src   (a_out_src),
        .sel_err   (a_sel_err)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a select token to the controlled instance and wait for it to be
    // taken; afterwards check the sel_err pulse in the following cycle.
    task automatic c_ctrl(input logic [1:0] sel);
        int waited;
        waited       = 0;
        c_ctrl_valid = 1'b1;
        c_ctrl_sel   = sel;
        #1;
        while (c_ctrl_ready !== 1'b1 && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        n_checks++;
        if (c_ctrl_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ctrl_ready_wait: got %b expected 1", c_ctrl_ready);
        end
        n_checks++;
        if (c_in_ready !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL idle_in_ready: got %b expected 000", c_in_ready);
        end
        tick();
        c_ctrl_valid = 1'b0;
        n_checks++;
        if (c_sel_err !== (sel == 2'd3)) begin
            n_fail++;
            $display("[TB] FAIL sel_err_pulse: got %b expected %b", c_sel_err, (sel == 2'd3));
        end
    endtask

    // Present a word on input 'target' while every other input also shows a
    // valid word; only the target may ever see in_ready.
    task automatic c_data(input int target, input logic [W-1:0] data);
        int         waited;
        logic [2:0] others;
        waited = 0;
        for (int i = 0; i < 3; i++) begin
            c_in_data[i*W +: W] = (i == target) ? data : W'($urandom);
        end
        c_in_valid = 3'b111;
        others     = 3'b111 & ~(3'b001 << target);
        #1;
        while (waited < 20) begin
            n_checks++;
            if ((c_in_ready & others) !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL unselected_in_ready: got %b expected %b", c_in_ready & others, 3'b000);
            end
            if (c_in_ready[target] === 1'b1) break;
            tick();
            #1;
            waited++;
        end
        n_checks++;
        if (c_in_ready[target] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL data_ready_wait: got %b expected 1", c_in_ready[target]);
        end
        tick();
        c_in_valid = 3'b000;
    endtask

    // One cycle of the arbitrated instance against the reference model.
    task automatic arb_cycle(input logic [3:0] vmask, input logic ordy,
                             output int winner, output logic [3:0] obs_ready);
        logic [3:0]  exp_ready;
        logic [12:0] head;
        int          idx;
        a_in_valid   = vmask;
        a_out_ready  = ordy;
        a_ctrl_valid = 1'b1;
        a_ctrl_sel   = 2'($urandom);
        for (int i = 0; i < 4; i++) begin
            a_in_data[i*W +: W] = a_prod[i];
        end
        #1;
        winner = -1;
        if (aq.size() < 2) begin
            for (int k = 0; k < 4; k++) begin
                idx = (a_ptr + k) % 4;
                if (winner < 0 && vmask[idx[1:0]]) winner = idx;
            end
        end
        exp_ready = (winner >= 0) ? (4'b0001 << winner) : 4'b0000;
        obs_ready = a_in_ready;
        n_checks++;
        if (a_in_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL arb_in_ready: got %b expected %b", a_in_ready, exp_ready);
        end
        n_checks++;
        if (a_out_valid !== (aq.size() > 0)) begin
            n_fail++;
            $display("[TB] FAIL arb_out_valid: got %b expected %b", a_out_valid, (aq.size() > 0));
        end
        if (aq.size() > 0) begin
            head = aq[0];
            n_checks++;
            if ({a_out_src, a_out_data} !== head) begin
                n_fail++;
                $display("[TB] FAIL arb_head: got src %0d data %h expected src %0d data %h",
                         a_out_src, a_out_data, head[12:11], head[10:0]);
            end
        end
        n_checks++;
        if (a_ctrl_ready !== 1'b0 || a_sel_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL arb_ctrl_tied: got ctrl_ready %b sel_err %b expected 0 0", a_ctrl_ready, a_sel_err);
        end
        if (aq.size() > 0 && ordy) void'(aq.pop_front());
        if (winner >= 0) begin
            aq.push_back({2'(winner), a_prod[winner]});
            a_ptr          = (winner + 1) % 4;
            a_prod[winner] = W'($urandom);
        end
        tick();
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        c_in_valid   = 3'b111;
        c_in_data    = '1;
        c_ctrl_valid = 1'b1;
        c_ctrl_sel   = 2'd1;
        c_out_ready  = 1'b0;
        a_in_valid   = 4'hF;
        a_in_data    = '1;
        a_ctrl_valid = 1'b1;
        a_ctrl_sel   = 2'd0;
        a_out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (c_in_ready !== 3'b000 || c_ctrl_ready !== 1'b0 || c_sel_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got in_ready %b ctrl_ready %b sel_err %b expected 000 0 0",
                     c_in_ready, c_ctrl_ready, c_sel_err);
        end
        n_checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== '0 || c_out_src !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_out: got valid %b data %h src %0d expected 0 000 0",
                     c_out_valid, c_out_data, c_out_src);
        end
        n_checks++;
        if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_arb: got in_ready %b out_valid %b expected 0000 0", a_in_ready, a_out_valid);
        end
        c_in_valid   = 3'b000;
        c_ctrl_valid = 1'b0;
        a_in_valid   = 4'h0;
        a_ctrl_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        n_checks++;
        if (c_ctrl_ready !== 1'b1 || c_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got ctrl_ready %b out_valid %b expected 1 0", c_ctrl_ready, c_out_valid);
        end
    endtask

    task automatic test_controlled_basic;
        logic [W-1:0] words [3];
        words[0]    = 11'h011;
        words[1]    = 11'h122;
        words[2]    = 11'h7FF;
        c_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_ctrl(2'(i));
            c_data(i, words[i]);
            n_checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== words[i] || c_out_src !== 2'(i)) begin
                n_fail++;
                $display("[TB] FAIL basic_out: got valid %b data %h src %0d expected 1 %h %0d",
                         c_out_valid, c_out_data, c_out_src, words[i], i);
            end
        end
        tick();
        n_checks++;
        if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_drained: got %b expected 0", c_out_valid);
        end
    endtask

    task automatic test_sel_err;
        c_out_ready = 1'b1;
        c_ctrl(2'd3);
        c_data(2, 11'h055);
        n_checks++;
        if (c_sel_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sel_err_width: got %b expected 0", c_sel_err);
        end
        n_checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== 11'h055 || c_out_src !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL sel_err_word: got valid %b data %h src %0d expected 1 055 2",
                     c_out_valid, c_out_data, c_out_src);
        end
        tick();
        n_checks++;
        if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sel_err_single: got %b expected 0", c_out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] w1, w2, w3;
        w1          = 11'h1A1;
        w2          = 11'h2B2;
        w3          = 11'h3C3;
        c_out_ready = 1'b0;
        c_ctrl(2'd0);
        c_data(0, w1);
        n_checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== w1) begin
            n_fail++;
            $display("[TB] FAIL bp_first: got valid %b data %h expected 1 %h", c_out_valid, c_out_data, w1);
        end
        c_ctrl(2'd1);
        c_data(1, w2);
        n_checks++;
        if (c_out_data !== w1 || c_out_src !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL bp_head_held: got data %h src %0d expected %h 0", c_out_data, c_out_src, w1);
        end
        c_ctrl(2'd2);
        c_in_data[0*W +: W] = W'($urandom);
        c_in_data[1*W +: W] = W'($urandom);
        c_in_data[2*W +: W] = w3;
        c_in_valid          = 3'b111;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (c_in_ready !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL bp_full_ready: got %b expected 000", c_in_ready);
            end
            tick();
            #1;
        end
        c_out_ready = 1'b1;
        #1;
        n_checks++;
        if (c_in_ready !== 3'b000 || c_out_data !== w1) begin
            n_fail++;
            $display("[TB] FAIL bp_pop_while_full: got in_ready %b data %h expected 000 %h", c_in_ready, c_out_data, w1);
        end
        tick();
        #1;
        n_checks++;
        if (c_in_ready !== 3'b100 || c_out_data !== w2 || c_out_src !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL bp_second: got in_ready %b data %h src %0d expected 100 %h 1",
                     c_in_ready, c_out_data, c_out_src, w2);
        end
        tick();
        c_in_valid = 3'b000;
        n_checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== w3 || c_out_src !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL bp_third: got valid %b data %h src %0d expected 1 %h 2",
                     c_out_valid, c_out_data, c_out_src, w3);
        end
        tick();
        n_checks++;
        if (c_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_drained: got %b expected 0", c_out_valid);
        end
    endtask

    task automatic test_controlled_random;
        logic [1:0]   sel;
        logic [W-1:0] data;
        int           target;
        c_out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            sel    = 2'($urandom_range(0, 3));
            data   = W'($urandom);
            target = (sel == 2'd3) ? 2 : int'(sel);
            c_ctrl(sel);
            c_data(target, data);
            n_checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== data || c_out_src !== 2'(target)) begin
                n_fail++;
                $display("[TB] FAIL rand_ctrl_out: got valid %b data %h src %0d expected 1 %h %0d",
                         c_out_valid, c_out_data, c_out_src, data, target);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid;
        c_out_ready = 1'b0;
        c_ctrl(2'd1);
        c_data(1, 11'h3A5);
        n_checks++;
        if (c_out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_one_word: got %b expected 1", c_out_valid);
        end
        c_ctrl(2'd0);
        #1;
        n_checks++;
        if (c_in_ready !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL mid_wait_data: got %b expected 001", c_in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 3'b000 || c_ctrl_ready !== 1'b0 || c_out_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_now: got valid %b in_ready %b ctrl_ready %b data %h expected 0 000 0 000",
                     c_out_valid, c_in_ready, c_ctrl_ready, c_out_data);
        end
        tick();
        rst_n       = 1'b1;
        c_in_valid  = 3'b111;
        c_out_ready = 1'b1;
        tick();
        n_checks++;
        if (c_ctrl_ready !== 1'b1 || c_in_ready !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL mid_back_idle: got ctrl_ready %b in_ready %b expected 1 000", c_ctrl_ready, c_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (c_out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_old_word: got %b expected 0", c_out_valid);
            end
            tick();
        end
        c_in_valid = 3'b000;
    endtask

    task automatic test_arb_all_valid;
        int         w;
        logic [3:0] obs;
        a_ptr = 0;
        aq.delete();
        for (int i = 0; i < 4; i++) a_prod[i] = W'($urandom);
        for (int i = 0; i < 10; i++) begin
            arb_cycle(4'hF, 1'b1, w, obs);
            n_checks++;
            if (obs !== (4'b0001 << (i % 4))) begin
                n_fail++;
                $display("[TB] FAIL arb_rotation: got %b expected %b", obs, 4'b0001 << (i % 4));
            end
        end
    endtask

    task automatic test_arb_sparse;
        int         w;
        logic [3:0] obs;
        logic [3:0] expect_seq [3];
        expect_seq[0] = 4'b1000;
        expect_seq[1] = 4'b0010;
        expect_seq[2] = 4'b1000;
        for (int i = 0; i < 3; i++) arb_cycle(4'h0, 1'b1, w, obs);
        for (int i = 0; i < 3; i++) begin
            arb_cycle(4'b1010, 1'b1, w, obs);
            n_checks++;
            if (obs !== expect_seq[i]) begin
                n_fail++;
                $display("[TB] FAIL arb_sparse_grant: got %b expected %b", obs, expect_seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) arb_cycle(4'h0, 1'b1, w, obs);
    endtask

    task automatic test_arb_random;
        int         w;
        logic [3:0] obs;
        logic [3:0] pending;
        pending = 4'h0;
        for (int n = 0; n < 300; n++) begin
            pending = pending | (4'($urandom) & 4'($urandom));
            arb_cycle(pending, ($urandom_range(0, 3) != 0), w, obs);
            if (w >= 0) pending[w] = 1'b0;
        end
        for (int i = 0; i < 4; i++) arb_cycle(4'h0, 1'b1, w, obs);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL arb_drained: got %b expected 0", a_out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_controlled_basic();
        test_sel_err();
        test_backpressure();
        test_controlled_random();
        test_reset_mid();
        test_arb_all_valid();
        test_arb_sparse();
        test_arb_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
